// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: segment bit positions,
// the hex glyph table and the output polarity helper.
package seg7_pkg;

   typedef logic [7:0] seg_byte_t;

   localparam int SEG_A  = 0;
   localparam int SEG_B  = 1;
   localparam int SEG_C  = 2;
   localparam int SEG_D  = 3;
   localparam int SEG_E  = 4;
   localparam int SEG_F  = 5;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Entry [n] is the {dp,g,f,e,d,c,b,a} glyph for nibble n, 1 = lit, dp clear.
   localparam logic [15:0][7:0] HEX_SEG_TABLE = {
      8'h71, 8'h79, 8'h5E, 8'h39, 8'h7C, 8'h77, 8'h6F, 8'h7F,
      8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
   };

   function automatic seg_byte_t apply_polarity(input seg_byte_t val, input logic active_low);
      return active_low ? ~val : val;
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment glyph, decimal point passed through.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] hex_i,
   input  logic       dp_i,
   output seg_byte_t  seg_o
);

   always_comb begin
      seg_o         = HEX_SEG_TABLE[hex_i];
      seg_o[SEG_DP] = dp_i;
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with refresh prescaler,
// per-frame input snapshot, PWM brightness and anti-ghosting guard interval.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 100000,
   parameter int GUARD_CYCLES   = 16,
   parameter int BRIGHT_W       = 4,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] hex_in,
   input  logic [8*NUM_DIGITS-1:0] raw_in,
   input  logic                    raw_mode,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   input  logic [BRIGHT_W-1:0]     brightness,
   input  logic                    update_en,
   output logic [NUM_DIGITS-1:0]   AN,
   output logic [7:0]              segment,
   output logic                    frame_done
);

   localparam int PRESC_W = $clog2(REFRESH_DIV);
   localparam int IDX_W   = $clog2(NUM_DIGITS);
   localparam logic [PRESC_W-1:0] PRESC_TC  = PRESC_W'(REFRESH_DIV - 1);
   localparam logic [PRESC_W-1:0] GUARD_END = PRESC_W'(GUARD_CYCLES);
   localparam logic [IDX_W-1:0]   IDX_TOP   = IDX_W'(NUM_DIGITS - 1);

   logic [PRESC_W-1:0]      presc_q, presc_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BRIGHT_W-1:0]     pwm_q;

   logic [4*NUM_DIGITS-1:0] snap_hex_q;
   logic [8*NUM_DIGITS-1:0] snap_raw_q;
   logic                    snap_raw_mode_q;
   logic [NUM_DIGITS-1:0]   snap_dp_q;
   logic [NUM_DIGITS-1:0]   snap_blank_q;
   logic [BRIGHT_W-1:0]     snap_bright_q;

   logic [NUM_DIGITS-1:0]   an_q, an_d, an_raw;
   seg_byte_t               seg_q, seg_d, seg_raw;
   logic                    frame_done_q, frame_done_d;
   logic                    tc, frame_end, lit;

   seg_byte_t               digit_seg [NUM_DIGITS];

   // Each digit's glyph is ready in parallel; the scan index only selects one.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      seg_byte_t dec_seg;

      seg7_hex_decode u_dec (
         .hex_i (snap_hex_q[4*gi +: 4]),
         .dp_i  (snap_dp_q[gi]),
         .seg_o (dec_seg)
      );

      assign digit_seg[gi] = snap_raw_mode_q ? snap_raw_q[8*gi +: 8] : dec_seg;
   end

   always_comb begin
      tc        = (presc_q == PRESC_TC);
      frame_end = tc && (idx_q == '0);
      presc_d   = tc ? '0 : presc_q + 1'b1;
      idx_d     = idx_q;
      if (tc) begin
         idx_d = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
      end

      // frame_done is registered but lines up with the terminal-count cycle of digit 0.
      frame_done_d = (presc_d == PRESC_TC) && (idx_d == '0);

      lit     = (presc_q >= GUARD_END) && (pwm_q <= snap_bright_q) && !snap_blank_q[idx_q];
      an_raw  = '0;
      seg_raw = '0;
      if (lit) begin
         an_raw[idx_q] = 1'b1;
         seg_raw       = digit_seg[idx_q];
      end

      an_d  = an_raw ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
      seg_d = apply_polarity(seg_raw, SEG_ACTIVE_LOW);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q         <= '0;
         idx_q           <= IDX_TOP;
         pwm_q           <= '0;
         snap_hex_q      <= '0;
         snap_raw_q      <= '0;
         snap_raw_mode_q <= 1'b0;
         snap_dp_q       <= '0;
         snap_blank_q    <= '1;
         snap_bright_q   <= '0;
         an_q            <= {NUM_DIGITS{AN_ACTIVE_LOW}};
         seg_q           <= {8{SEG_ACTIVE_LOW}};
         frame_done_q    <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         pwm_q        <= pwm_q + 1'b1;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_done_q <= frame_done_d;
         if (frame_end && update_en) begin
            snap_hex_q      <= hex_in;
            snap_raw_q      <= raw_in;
            snap_raw_mode_q <= raw_mode;
            snap_dp_q       <= dp_in;
            snap_blank_q    <= blank_in;
            snap_bright_q   <= brightness;
         end
      end
   end

   assign AN         = an_q;
   assign segment    = seg_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: cycle-count based reference model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_seg7_scan_driver;

   localparam int N  = 4;
   localparam int D  = 8;
   localparam int G  = 1;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   hex_in = '0;
   logic [31:0]   raw_in = '0;
   logic          raw_mode = 1'b0;
   logic [3:0]    dp_in = '0;
   logic [3:0]    blank_in = '0;
   logic [1:0]    brightness = '0;
   logic          update_en = 1'b1;
   logic [3:0]    AN;
   logic [7:0]    segment;
   logic          frame_done;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .NUM_DIGITS     (N),
      .REFRESH_DIV    (D),
      .GUARD_CYCLES   (G),
      .BRIGHT_W       (BW),
      .AN_ACTIVE_LOW  (1'b1),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .hex_in     (hex_in),
      .raw_in     (raw_in),
      .raw_mode   (raw_mode),
      .dp_in      (dp_in),
      .blank_in   (blank_in),
      .brightness (brightness),
      .update_en  (update_en),
      .AN         (AN),
      .segment    (segment),
      .frame_done (frame_done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input bit verbose);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end else if (verbose) begin
         $display("check %s @%0t: got 0x%0h, expected 0x%0h ok", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  HEX_TBL [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
   int          k;
   bit          model_valid = 1'b0;
   logic [15:0] m_hex;
   logic [31:0] m_raw;
   logic        m_mode;
   logic [3:0]  m_dp, m_blank;
   logic [1:0]  m_bright;
   logic [3:0]  exp_an;
   logic [7:0]  exp_seg;
   logic        exp_fd;
   int          m_presc, m_idx, m_pwm;
   bit          m_lit;

   function automatic logic [7:0] model_byte(input int d);
      logic [3:0] nib;
      if (m_mode) return m_raw[8*d +: 8];
      nib = m_hex[4*d +: 4];
      return HEX_TBL[nib] | {m_dp[d], 7'b0};
   endfunction

   // k = clk edges since the reset edge; everything else follows arithmetically.
   task automatic model_step();
      if (rst) begin
         k = 0;
         exp_an = 4'hF; exp_seg = 8'hFF; exp_fd = 1'b0;
         m_hex = '0; m_raw = '0; m_mode = 1'b0; m_dp = '0; m_blank = 4'hF; m_bright = '0;
         model_valid = 1'b1;
      end else if (model_valid) begin
         m_presc = k % D;
         m_idx   = N - 1 - (k / D) % N;
         m_pwm   = k % (1 << BW);
         m_lit   = (m_presc >= G) && (m_pwm <= int'(m_bright)) && !m_blank[m_idx];
         exp_an  = 4'hF;
         exp_seg = 8'hFF;
         if (m_lit) begin
            exp_an[m_idx] = 1'b0;
            exp_seg = ~model_byte(m_idx);
         end
         if (m_presc == D - 1 && m_idx == 0 && update_en) begin
            m_hex = hex_in; m_raw = raw_in; m_mode = raw_mode;
            m_dp = dp_in; m_blank = blank_in; m_bright = brightness;
         end
         k++;
         exp_fd = (k % D == D - 1) && ((N - 1 - (k / D) % N) == 0);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (model_valid) begin
         chk("AN", AN, exp_an, 1'b0);
         chk("segment", segment, exp_seg, 1'b0);
         chk("frame_done", frame_done, exp_fd, 1'b0);
         chk("an_at_most_one", ($countones(~AN) <= 1), 1'b1, 1'b0);
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_fd(input string name, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < 200);
      if (!frame_done) chk({name, "_timeout"}, frame_done, 1'b1, 1'b1);
   endtask

   task automatic wait_fd_dark(input string name, output int n, output int dark_bad);
      n = 0;
      dark_bad = 0;
      do begin
         @(negedge clk);
         n++;
         if (AN !== 4'hF || segment !== 8'hFF) dark_bad++;
      end while (!frame_done && n < 200);
      if (!frame_done) chk({name, "_timeout"}, frame_done, 1'b1, 1'b1);
   endtask

   logic [3:0] LIT_AN  [4] = '{4'h7, 4'hB, 4'hD, 4'hE};
   logic [7:0] LIT_SEG [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

   initial begin
      int n, pre_bad;
      int cnt [4];

      // Reset release with 1234, full brightness
      hex_in = 16'h1234; brightness = 2'd3; update_en = 1'b1; rst = 1'b1;
      step(2);
      chk("reset_an", AN, 4'hF, 1'b1);
      chk("reset_seg", segment, 8'hFF, 1'b1);
      chk("reset_fd", frame_done, 1'b0, 1'b1);
      rst = 1'b0;
      wait_fd_dark("first_fd", n, pre_bad);
      chk("pre_frame_dark", pre_bad, 0, 1'b1);
      chk("first_fd_latency", n, 31, 1'b1);
      step(2);
      chk("slot3_guard_an", AN, 4'hF, 1'b1);
      for (int m = 0; m < 4; m++) begin
         step(m == 0 ? 1 : 8);
         chk("scan_an", AN, LIT_AN[m], 1'b1);
         chk("scan_seg", segment, LIT_SEG[m], 1'b1);
      end

      // Mid-frame change with update_en=1, then freeze with update_en=0
      wait_fd("midframe_fd", n);
      step(12);
      hex_in = 16'h8888;
      step(15);
      chk("midframe_hold_an", AN, 4'hE, 1'b1);
      chk("midframe_hold_seg", segment, 8'h99, 1'b1);
      wait_fd("update_fd", n);
      step(3);
      chk("after_update_seg", segment, 8'h80, 1'b1);
      update_en = 1'b0;
      hex_in = 16'h0000;
      wait_fd("frozen_fd1", n);
      wait_fd("frozen_fd2", n);
      step(3);
      chk("frozen_seg", segment, 8'h80, 1'b1);
      update_en = 1'b1;

      // Raw mode: only the dp of digit 2
      raw_mode = 1'b1;
      raw_in = 32'h0080_0000;
      wait_fd("raw_fd", n);
      step(3);
      chk("raw_d3_an", AN, 4'h7, 1'b1);
      chk("raw_d3_seg", segment, 8'hFF, 1'b1);
      step(8);
      chk("raw_d2_an", AN, 4'hB, 1'b1);
      chk("raw_d2_seg", segment, 8'h7F, 1'b1);

      // Blanking and reduced brightness
      raw_mode = 1'b0;
      hex_in = 16'h1234;
      blank_in = 4'b0101;
      brightness = 2'd1;
      wait_fd("blank_fd", n);
      step(1);
      for (int d = 0; d < 4; d++) cnt[d] = 0;
      for (int j = 2; j <= 33; j++) begin
         step(1);
         for (int d = 0; d < 4; d++) if (AN[d] === 1'b0) cnt[d]++;
      end
      chk("blank_d0_lit", cnt[0], 0, 1'b1);
      chk("blank_d2_lit", cnt[2], 0, 1'b1);
      chk("pwm_d1_lit", cnt[1], 3, 1'b1);
      chk("pwm_d3_lit", cnt[3], 3, 1'b1);

      // Reset during the digit-1 slot
      blank_in = 4'b0000;
      brightness = 2'd3;
      wait_fd("prereset_fd", n);
      step(19);
      chk("prereset_d1_an", AN, 4'hD, 1'b1);
      chk("prereset_d1_seg", segment, 8'hB0, 1'b1);
      rst = 1'b1;
      step(1);
      chk("midreset_an", AN, 4'hF, 1'b1);
      chk("midreset_seg", segment, 8'hFF, 1'b1);
      rst = 1'b0;
      wait_fd_dark("postreset_fd", n, pre_bad);
      chk("postreset_dark", pre_bad, 0, 1'b1);
      chk("postreset_fd_latency", n, 31, 1'b1);
      step(2);
      chk("postreset_guard_an", AN, 4'hF, 1'b1);
      step(1);
      chk("postreset_d3_an", AN, 4'h7, 1'b1);
      chk("postreset_d3_seg", segment, 8'hF9, 1'b1);

      // Randomized stimulus against the model
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         if ($urandom_range(3) == 0) hex_in = 16'($urandom);
         if ($urandom_range(3) == 0) raw_in = $urandom;
         if ($urandom_range(7) == 0) raw_mode = ~raw_mode;
         if ($urandom_range(3) == 0) dp_in = 4'($urandom);
         if ($urandom_range(5) == 0) blank_in = 4'($urandom);
         if ($urandom_range(5) == 0) brightness = 2'($urandom);
         update_en = ($urandom_range(3) != 0);
         rst = ($urandom_range(499) == 0);
      end
      rst = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised time-multiplexed seven-segment display driver for N digits.
- Successor to the fixed 4-digit, 1-clock-per-digit scanner: adds a refresh prescaler, hex/raw decode modes, per-digit blank and decimal point, PWM brightness, an anti-ghosting guard interval and selectable output polarity.
- Sits between CPU-visible display registers (MMIO) and board AN/segment pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_DIV, 100000, clk cycles per digit slot (>= 2*GUARD_CYCLES+2).
- GUARD_CYCLES, 16, cycles at start of each slot with all anodes off.
- BRIGHT_W, 4, brightness control width.
- AN_ACTIVE_LOW, 1, 1 = anode enable driven low.
- SEG_ACTIVE_LOW, 1, 1 = lit segment driven low.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- hex_in  in  4*NUM_DIGITS  nibble per digit; digit 0 = bits [3:0]
- raw_in  in  8*NUM_DIGITS  raw segment byte per digit {dp,g,f,e,d,c,b,a}, 1 = lit
- raw_mode  in  1  1 = use raw_in, 0 = decode hex_in
- dp_in  in  NUM_DIGITS  decimal point per digit (hex mode only)
- blank_in  in  NUM_DIGITS  1 = digit dark
- brightness  in  BRIGHT_W  PWM duty
- update_en  in  1  1 = snapshot inputs each frame; 0 = freeze display
- AN  out  NUM_DIGITS  anode enables (polarity per AN_ACTIVE_LOW)
- segment  out  8  {dp,g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
- frame_done  out  1  one-cycle pulse at the end of the last slot of a frame

Behaviour:
- Clock is clk; reset is synchronous and active-high on rst. Every register is reset only on the clk edge with rst=1.
- Reset values:
  - AN all inactive; segment all unlit (polarity applied).
  - frame_done=0.
  - Prescaler 0, digit index NUM_DIGITS-1, PWM counter 0.
  - Snapshot registers cleared to 0 with blank=all-ones, so nothing lights until the first snapshot.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - At terminal count (TC), digit index decrements, scanning MSB digit first; from 0 it wraps to NUM_DIGITS-1.
- Frame snapshot:
  - At TC with index==0, frame_done pulses in that same cycle.
  - If update_en=1, all inputs are copied into snapshot registers on that edge, so a new frame never tears.
  - update_en=0 holds the previous snapshot.
  - Inputs changing mid-frame have no effect until the next frame boundary.
- Decode: hex mode uses the table below; dp comes from dp_in. Raw mode passes the raw byte, including its dp bit.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Brightness:
  - A free-running BRIGHT_W-bit PWM counter increments every clk.
  - Digit lit condition: pwm_cnt <= brightness. All-ones = 100%; 0 = 1/2^BRIGHT_W duty.
- Guard interval: while prescaler < GUARD_CYCLES, AN is all inactive and segment is unlit.
- Output: AN one-hot on the current index only when all of these hold:
  - not in guard;
  - PWM on;
  - snapshot blank bit = 0.
  - Otherwise AN is all inactive and segment is unlit.
- Outputs are registered: AN/segment reflect prescaler, index and PWM state of the previous cycle (1-cycle latency).
- Never more than one anode is active in any cycle. Polarity inversion is applied last.
- Reset mid-frame: outputs go inactive on the next edge, and the scan restarts at NUM_DIGITS-1 with the prescaler at 0.

Decomposition:
- Package seg7_pkg holds:
  - the 16-entry hex-to-segment constant table;
  - segment bit-position localparams (SEG_A..SEG_DP);
  - a function applying polarity.
- One sub-module, seg7_hex_decode: combinational nibble + dp -> 8-bit segment byte. Used by the driver and reusable elsewhere.
- Prescaler, scan index, PWM and snapshot logic stay in seg7_scan_driver.

Test Plan:
- Test configuration: NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=1, BRIGHT_W=2, both polarities active-low.
- Reset release with hex_in=16'h1234, brightness=3, update_en=1:
  - AN=4'hF and segment=8'hFF until the first frame_done.
  - Next frame: AN=0111 with seg=~06, then 1011/~5B, 1101/~4F, 1110/~66. Each slot lasts 7 lit cycles after 1 guard cycle.
- Raw mode, raw_in digit2=8'h80, others 0: only dp is lit during the digit-2 slot (seg=8'h7F when AN=1011).
- blank_in=4'b0101 and brightness=1:
  - Digits 0 and 2 are never enabled.
  - Digits 1 and 3 are lit exactly 2 of every 4 cycles outside the guard interval.
- Change hex_in mid-frame with update_en=1: no segment change until after the next frame_done. With update_en=0: no change ever.
- Assert rst during the digit-1 slot: the next cycle gives AN=F and segment=FF; after release, scan resumes at digit 3 with the full guard interval.
- Throughout all tests, assert each cycle that AN has at most one active bit.
